dpe_tile_sched: RTL
===================

DPE_TILE_SCHED -- requirements
Module: dpe_tile_sched

Interface
REQ-001 SHALL have parameter BLOCK_SIZE_WIDTH, default 6, width of block-size field passed to the DPE.
REQ-002 SHALL have parameter KCNT_WIDTH, default 8, width of the accumulation-pass count.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles waited for dpe_done per pass.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  reset.
- cmd_valid  in  1  tile command valid.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_kblocks  in  KCNT_WIDTH  number of accumulation passes.
- cmd_block_size  in  BLOCK_SIZE_WIDTH  block size per pass.
- cmd_bias_en  in  1  preload bias before first pass.
- cmd_relu_en  in  1  apply ReLU at write-back.
- start_op  out  1  DPE pass start pulse.
- bias_load_en  out  1  DPE bias load.
- relu_en  out  1  DPE ReLU enable.
- acc_buffer_sel  out  1  DPE accumulation buffer select.
- write_back  out  1  DPE write-back pulse.
- clear_buffer  out  1  DPE buffer clear pulse.
- block_size  out  BLOCK_SIZE_WIDTH  latched block size to DPE.
- dpe_done  in  1  DPE pass complete.
- r_depend  in  1  DPE read dependency pending.
- w_depend  in  1  DPE write dependency pending.
- rsp_valid  out  1  tile complete, one-cycle pulse.
- rsp_err  out  1  qualifies rsp_valid: tile aborted.
- busy  out  1  not in IDLE.
REQ-005 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-006 SHALL implement states IDLE, BIAS, ISSUE, WAIT, WB, CLEAR, RSP.
REQ-007 SHALL assert cmd_ready only in IDLE; accept on cmd_valid&&cmd_ready, latching all cmd_* fields; block_size output SHALL equal the latched value.
REQ-008 SHALL, on accept with cmd_kblocks==0, go directly to RSP with rsp_err=1 and no DPE strobes.
REQ-009 SHALL, on accept with kblocks>0, go to BIAS if bias_en else ISSUE.
REQ-010 SHALL assert bias_load_en for exactly one cycle in BIAS, then go to ISSUE.
REQ-011 SHALL in ISSUE hold while r_depend==1; when r_depend==0, pulse start_op one cycle, clear timeout counter, go to WAIT.
REQ-012 SHALL in WAIT, on dpe_done, increment pass counter; if count==kblocks go to WB, else to ISSUE.
REQ-013 SHALL in WAIT, if timeout counter reaches TIMEOUT-1 without dpe_done, set error flag and go to CLEAR (skip WB); dpe_done in that same cycle takes priority over timeout.
REQ-014 SHALL in WB hold while w_depend==1; when 0, pulse write_back one cycle and go to CLEAR; relu_en SHALL equal latched relu_en in WB, else 0.
REQ-015 SHALL in CLEAR pulse clear_buffer one cycle, toggle acc_buffer_sel registered at exit, go to RSP.
REQ-016 SHALL in RSP pulse rsp_valid one cycle with rsp_err=error flag, then return to IDLE; rsp_err SHALL be 0 when rsp_valid==0.
REQ-017 SHALL ignore dpe_done outside WAIT.
REQ-018 SHALL drive all DPE strobes from registers (no combinational path from inputs to outputs).
REQ-019 Pass counter SHALL be KCNT_WIDTH+1 bits so kblocks=2^KCNT_WIDTH-1 completes without wrap.

Reset
REQ-020 SHALL on reset enter IDLE and clear counters, error flag, latched fields; all outputs 0 except cmd_ready=1; acc_buffer_sel=0.
REQ-021 SHALL on reset mid-tile abandon the tile with no rsp_valid.

Structure
REQ-022 SHALL place the state enum and default parameter constants in a shared package dpe_pkg.
REQ-023 SHALL be a single module; the timeout counter MAY be sub-module dpe_watchdog.

Verification
REQ-024 kblocks=3, bias_en=1, deps low, dpe_done 5 cycles after each start_op -> 1 bias_load_en, 3 start_op, 1 write_back, 1 clear_buffer, rsp_valid with rsp_err=0, acc_buffer_sel 0->1.
REQ-025 kblocks=0 -> rsp_valid one cycle after accept with rsp_err=1, no strobes.
REQ-026 r_depend high 4 cycles in ISSUE, w_depend high 3 cycles in WB -> start_op and write_back delayed by exactly 4 and 3 cycles.
REQ-027 TIMEOUT=16, dpe_done never -> clear_buffer 16 cycles after start_op, no write_back, rsp_err=1.
REQ-028 reset asserted in WAIT of pass 2 -> IDLE next cycle, cmd_ready=1, no rsp_valid; next command runs normally.
REQ-029 two back-to-back tiles, relu_en=1 -> relu_en high only during WB; acc_buffer_sel 0->1->0.

Source files
------------

// File: rtl/dpe_pkg.sv
// rtl/dpe_pkg.sv - shared state encoding and default parameters for the DPE tile scheduler
package dpe_pkg;

    localparam int DEF_BLOCK_SIZE_WIDTH = 6;
    localparam int DEF_KCNT_WIDTH       = 8;
    localparam int DEF_TIMEOUT          = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_CLEAR,
        ST_RSP
    } sched_state_t;

endpackage

// File: rtl/dpe_watchdog.sv
// rtl/dpe_watchdog.sv - per-pass timeout counter, flags expiry at TIMEOUT-1 cycles
module dpe_watchdog
    import dpe_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LIMIT so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/dpe_tile_sched.sv
// rtl/dpe_tile_sched.sv - sequences bias, accumulation passes, write-back and clear for one DPE tile
module dpe_tile_sched
    import dpe_pkg::*;
#(
    parameter int BLOCK_SIZE_WIDTH = DEF_BLOCK_SIZE_WIDTH,
    parameter int KCNT_WIDTH       = DEF_KCNT_WIDTH,
    parameter int TIMEOUT          = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [KCNT_WIDTH-1:0]       cmd_kblocks,
    input  logic [BLOCK_SIZE_WIDTH-1:0] cmd_block_size,
    input  logic                        cmd_bias_en,
    input  logic                        cmd_relu_en,
    output logic                        start_op,
    output logic                        bias_load_en,
    output logic                        relu_en,
    output logic                        acc_buffer_sel,
    output logic                        write_back,
    output logic                        clear_buffer,
    output logic [BLOCK_SIZE_WIDTH-1:0] block_size,
    input  logic                        dpe_done,
    input  logic                        r_depend,
    input  logic                        w_depend,
    output logic                        rsp_valid,
    output logic                        rsp_err,
    output logic                        busy
);

    sched_state_t state, state_n;

    logic [KCNT_WIDTH-1:0]       kblocks_q;
    logic [BLOCK_SIZE_WIDTH-1:0] block_size_q;
    logic                        relu_en_q;
    logic                        err_q, err_n;
    logic [KCNT_WIDTH:0]         pass_cnt, pass_cnt_n;
    logic                        accept;
    logic                        wd_expired;

    logic start_op_d, bias_load_en_d, relu_en_d, write_back_d, clear_buffer_d;
    logic rsp_valid_d, rsp_err_d, busy_d, cmd_ready_d;

    assign accept     = cmd_valid && cmd_ready;
    assign block_size = block_size_q;

    dpe_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            err_q          <= 1'b0;
            pass_cnt       <= '0;
            kblocks_q      <= '0;
            block_size_q   <= '0;
            relu_en_q      <= 1'b0;
            acc_buffer_sel <= 1'b0;
        end else begin
            state    <= state_n;
            err_q    <= err_n;
            pass_cnt <= pass_cnt_n;
            if (accept) begin
                kblocks_q    <= cmd_kblocks;
                block_size_q <= cmd_block_size;
                relu_en_q    <= cmd_relu_en;
            end
            // Ping-pong buffer flips once the current one has been cleared.
            if (state == ST_CLEAR) begin
                acc_buffer_sel <= ~acc_buffer_sel;
            end
        end
    end

    always_comb begin
        state_n    = state;
        err_n      = err_q;
        pass_cnt_n = pass_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    err_n      = 1'b0;
                    pass_cnt_n = '0;
                    if (cmd_kblocks == '0) begin
                        err_n   = 1'b1;
                        state_n = ST_RSP;
                    end else if (cmd_bias_en) begin
                        state_n = ST_BIAS;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end
            end
            ST_BIAS:  state_n = ST_ISSUE;
            ST_ISSUE: if (!r_depend) state_n = ST_WAIT;
            ST_WAIT: begin
                // A completion in the expiry cycle still counts as a good pass.
                if (dpe_done) begin
                    pass_cnt_n = pass_cnt + 1'b1;
                    state_n    = (pass_cnt_n == {1'b0, kblocks_q}) ? ST_WB : ST_ISSUE;
                end else if (wd_expired) begin
                    err_n   = 1'b1;
                    state_n = ST_CLEAR;
                end
            end
            ST_WB:    if (!w_depend) state_n = ST_CLEAR;
            ST_CLEAR: state_n = ST_RSP;
            ST_RSP:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        start_op_d     = (state == ST_ISSUE) && !r_depend;
        bias_load_en_d = (state_n == ST_BIAS);
        relu_en_d      = (state_n == ST_WB) && relu_en_q;
        write_back_d   = (state == ST_WB) && !w_depend;
        clear_buffer_d = (state_n == ST_CLEAR);
        rsp_valid_d    = (state_n == ST_RSP);
        rsp_err_d      = (state_n == ST_RSP) && err_n;
        busy_d         = (state_n != ST_IDLE);
        cmd_ready_d    = (state_n == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_op     <= 1'b0;
            bias_load_en <= 1'b0;
            relu_en      <= 1'b0;
            write_back   <= 1'b0;
            clear_buffer <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
        end else begin
            start_op     <= start_op_d;
            bias_load_en <= bias_load_en_d;
            relu_en      <= relu_en_d;
            write_back   <= write_back_d;
            clear_buffer <= clear_buffer_d;
            rsp_valid    <= rsp_valid_d;
            rsp_err      <= rsp_err_d;
            busy         <= busy_d;
            cmd_ready    <= cmd_ready_d;
        end
    end

endmodule
